npu_host_sequencer: RTL and testbench
=====================================

# npu_host_sequencer

Synthesizable host-side sequencer that drives the NPU's `we`/`oe`/`data` word protocol from a valid/ready word stream and returns NPU results on a second stream. It generalises the bring-up load/compute/read flow in four ways: runtime counts, multi-iteration batches, an optional weight-reload skip, and backpressure on both sides. It sits between the host DMA/FIFO and the `npu` top.

## Interface
Parameters:
- `DATA_W`, default 32: NPU word width.
- `NUM_CFG`, default 6: number of configuration words per load (layers, in, h1, h2, out, act).
- `CNT_W`, default 12: width of every length/iteration counter.

Ports:
- `clk`, input, 1: sole clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle pulse; ignored unless idle.
- `num_w`, input, CNT_W: weight+bias word count; 0 means none.
- `num_in_m1`, input, CNT_W: input words minus one (NPU encoding).
- `num_out_m1`, input, CNT_W: output words minus one.
- `calc_cycles`, input, CNT_W: idle cycles between load end and first read.
- `num_iter`, input, CNT_W: iterations; 0 is treated as 1.
- `reload_w`, input, 1: 1 = resend cfg+weights every iteration; 0 = first iteration only.
- `wait_ready`, input, 1: 1 = CALC additionally waits for `npu_ready`.
- `src_valid`, `src_ready`, `src_data`: in/out/in, 1/1/DATA_W; word stream in cfg, weight, input order.
- `out_valid`, `out_ready`, `out_data`: out/in/out, 1/1/DATA_W; result stream.
- `npu_we`, `npu_oe`: output, 1: NPU strobes.
- `npu_data_o`, output, DATA_W; `npu_data_en`, output, 1: tristate drive value and enable.
- `npu_data_i`, input, DATA_W: bus readback.
- `npu_ready`, input, 1: NPU done.
- `busy`, output, 1; `done`, output, 1: one-cycle pulse after the last output word is accepted.

## Operation
- States: IDLE, CFG, WGT, INP, CALC, RD, DONE. Latch all count inputs on `start`.
- IDLE→CFG on `start`. CFG accepts NUM_CFG words→WGT (→INP if `num_w`=0). WGT accepts `num_w` words→INP. INP accepts `num_in_m1`+1 words→CALC.
- CALC counts `calc_cycles`. If `wait_ready`, it also requires `npu_ready`. It then moves to RD.
- RD issues `num_out_m1`+1 reads→DONE when the last word leaves on `out`.
- DONE: if iterations remain, next state is CFG when `reload_w`=1, else INP. Otherwise IDLE with a `done` pulse.
- `src_ready`=1 only in CFG/WGT/INP while the current segment count is not exhausted. Each accepted word is registered onto `npu_data_o` with `npu_we`=`npu_data_en`=1 for exactly one cycle.
- Source bubble (`src_valid`=0): drop `npu_we`/`npu_data_en` that cycle. Data is don't-care; the NPU ignores cycles with `we` low.
- RD: `npu_oe`=1 only when the 1-entry output register is empty or drains this cycle. `npu_data_i` is captured at the edge ending each `oe` cycle.
- `npu_we` and `npu_oe` are never both 1. `npu_data_en`=0 whenever `npu_oe`=1.
- `start` while busy is ignored. Counters are CNT_W-bit and never wrap; each segment terminates on equality with the latched count.
- Reset values: all outputs 0, state IDLE, output register empty. `rst` mid-operation aborts the transfer and drops `we`/`oe` in the same edge; no `done` is issued.

## Timing
- Word accepted at edge t appears with `npu_we`=1 in cycle t+1.
- Last input word's `we` cycle is followed immediately by CALC. The first `oe` cycle is `calc_cycles`+1 cycles after the last `we` cycle when `wait_ready`=0 and `out_ready`=1.
- Read sampled at edge t gives `out_valid`=1 from cycle t+1. With `out_ready` constantly 1, `oe` stays high for `num_out_m1`+1 consecutive cycles.
- `out_valid`/`out_data` hold stable until `out_ready`.
- `done` is asserted the cycle after the final output handshake; `busy` deasserts in the same cycle.

## Structure
- Package `npu_host_pkg`: state enum, `NUM_CFG` default, `DATA_W` default.
- Sub-module `npu_host_out_reg`: one-entry valid/ready holding register that supplies the `oe` permission signal.
- All counters live in the top module: one segment counter reused per state, plus an iteration counter.

## Test plan
- Single iteration, num_w=11, num_in_m1=9, num_out_m1=0, calc_cycles=5, no stalls → 27 consecutive `we` cycles; `oe` exactly 6 cycles after the last one; 1 output word; `done` pulse.
- num_iter=3, reload_w=0 → cfg+weights (17 words) sent once, inputs sent 3×; 3 outputs in order; `src` word count consumed = 17+30.
- Random `src_valid` gaps and `out_ready` held low for 4 cycles mid-RD (num_out_m1=3) → NPU sees the exact word sequence; no `oe` while the register is full; 4 outputs with no loss or duplication.
- wait_ready=1, calc_cycles=2, `npu_ready` rises 10 cycles after CALC entry → first `oe` the cycle after `npu_ready` is seen.
- num_w=0, num_iter=0 → WGT skipped, one iteration run.
- `rst` asserted during WGT; `start` pulsed while busy → all outputs 0 the next cycle and no `done`; the busy-time `start` is ignored and a following `start` runs cleanly.

Source files
------------

// File: rtl/npu_host_pkg.sv
// npu_host_pkg: shared defaults and the sequencer state type.
//   DATA_W_DEF  : default NPU word width
//   NUM_CFG_DEF : default configuration words per load
//   CNT_W_DEF   : default width of every length/iteration counter
//   state_e     : sequencer FSM states
package npu_host_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int NUM_CFG_DEF = 6;
    localparam int CNT_W_DEF   = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WGT,
        S_INP,
        S_CALC,
        S_RD,
        S_DONE
    } state_e;

endpackage

// File: rtl/npu_host_sequencer_if.sv
// npu_host_sequencer_if: host source stream, result stream and NPU bus bundle.
//   src_*    : host word stream into the sequencer (cfg, weights, inputs)
//   out_*    : NPU result stream out of the sequencer
//   npu_*    : NPU strobes, tristate drive value/enable, readback and ready
//   master   : sequencer side; slave : host/NPU side
interface npu_host_sequencer_if
    import npu_host_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              npu_we;
    logic              npu_oe;
    logic [DATA_W-1:0] npu_data_o;
    logic              npu_data_en;
    logic [DATA_W-1:0] npu_data_i;
    logic              npu_ready;

    modport master (
        input  src_valid, src_data, out_ready, npu_data_i, npu_ready,
        output src_ready, out_valid, out_data, npu_we, npu_oe, npu_data_o, npu_data_en
    );

    modport slave (
        output src_valid, src_data, out_ready, npu_data_i, npu_ready,
        input  src_ready, out_valid, out_data, npu_we, npu_oe, npu_data_o, npu_data_en
    );

endinterface

// File: rtl/npu_host_out_reg.sv
// npu_host_out_reg: one-entry valid/ready holding register for NPU readback.
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : capture load_data_i at this edge (an oe cycle)
//   can_load_o    : register is empty or drains this cycle, so a read may issue
//   out_valid_o, out_ready_i, out_data_o : result stream
module npu_host_out_reg
    import npu_host_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              can_load_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign can_load_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/npu_host_sequencer.sv
// npu_host_sequencer: drives the NPU we/oe/data word protocol from a host word stream.
//   clk, rst        : clock, synchronous active-high reset
//   start           : launch pulse, honoured only while idle
//   num_w, num_in_m1, num_out_m1, calc_cycles, num_iter, reload_w, wait_ready :
//                     job shape, latched on start
//   bus (master)    : host source stream, result stream and NPU bus
//   busy, done      : job in progress, one-cycle completion pulse
module npu_host_sequencer
    import npu_host_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_CFG = NUM_CFG_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_w,
    input  logic [CNT_W-1:0] num_in_m1,
    input  logic [CNT_W-1:0] num_out_m1,
    input  logic [CNT_W-1:0] calc_cycles,
    input  logic [CNT_W-1:0] num_iter,
    input  logic             reload_w,
    input  logic             wait_ready,
    npu_host_sequencer_if.master bus,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(NUM_CFG - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  seg_q, seg_d;
    logic [CNT_W-1:0]  iter_cnt_q, iter_cnt_d;
    logic              end_q, end_d;
    logic [CNT_W-1:0]  num_w_q, num_in_q, num_out_q, calc_q, iter_q;
    logic              reload_q, wait_q;
    logic              we_q;
    logic [DATA_W-1:0] data_q;
    logic              accept, oe, can_load, last_iter, rdy_ok, time_ok, go_rd;

    // end_q marks a segment whose last word/read has gone out but whose state must still be held
    assign bus.src_ready = (state_q == S_CFG) || (state_q == S_WGT) || (state_q == S_INP && !end_q);
    assign accept        = bus.src_valid && bus.src_ready;
    assign oe            = (state_q == S_RD) && !end_q && can_load;
    assign last_iter     = iter_cnt_q == iter_q - 1'b1;
    assign rdy_ok        = !wait_q || bus.npu_ready;
    // CALC is entered with seg_q = 1 so it lasts exactly calc_q cycles
    assign time_ok       = (seg_q == calc_q) || (calc_q == '0);
    assign go_rd         = (calc_q == '0) && rdy_ok;
    assign done          = (state_q == S_DONE) && last_iter;
    assign busy          = (state_q != S_IDLE) && !done;

    assign bus.npu_we      = we_q;
    assign bus.npu_data_en = we_q;
    assign bus.npu_data_o  = data_q;
    assign bus.npu_oe      = oe;

    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        end_d      = end_q;
        iter_cnt_d = iter_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CFG;
                    seg_d      = '0;
                    end_d      = 1'b0;
                    iter_cnt_d = '0;
                end
            end
            S_CFG: begin
                if (accept) begin
                    seg_d = (seg_q == CFG_LAST) ? '0 : seg_q + 1'b1;
                    if (seg_q == CFG_LAST) state_d = (num_w_q == '0) ? S_INP : S_WGT;
                end
            end
            S_WGT: begin
                if (accept) begin
                    seg_d = (seg_q == num_w_q - 1'b1) ? '0 : seg_q + 1'b1;
                    if (seg_q == num_w_q - 1'b1) state_d = S_INP;
                end
            end
            S_INP: begin
                // hold INP through the last word's we cycle so CALC follows it directly
                if (end_q) begin
                    end_d   = 1'b0;
                    state_d = go_rd ? S_RD : S_CALC;
                    seg_d   = go_rd ? '0 : CNT_W'(1);
                end else if (accept) begin
                    seg_d = seg_q + 1'b1;
                    end_d = seg_q == num_in_q;
                end
            end
            S_CALC: begin
                if (time_ok && rdy_ok) begin
                    state_d = S_RD;
                    seg_d   = '0;
                end else if (!time_ok) begin
                    seg_d = seg_q + 1'b1;
                end
            end
            S_RD: begin
                if (oe) begin
                    seg_d = seg_q + 1'b1;
                    end_d = seg_q == num_out_q;
                end
                // after the last read the holding register holds only the final word
                if (end_q && bus.out_valid && bus.out_ready) begin
                    state_d = S_DONE;
                    end_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (last_iter) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = reload_q ? S_CFG : S_INP;
                    seg_d      = '0;
                    iter_cnt_d = iter_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            seg_q      <= '0;
            end_q      <= 1'b0;
            iter_cnt_q <= '0;
            we_q       <= 1'b0;
            data_q     <= '0;
            num_w_q    <= '0;
            num_in_q   <= '0;
            num_out_q  <= '0;
            calc_q     <= '0;
            iter_q     <= CNT_W'(1);
            reload_q   <= 1'b0;
            wait_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            end_q      <= end_d;
            iter_cnt_q <= iter_cnt_d;
            we_q       <= accept;
            if (accept) data_q <= bus.src_data;
            if (state_q == S_IDLE && start) begin
                num_w_q   <= num_w;
                num_in_q  <= num_in_m1;
                num_out_q <= num_out_m1;
                calc_q    <= calc_cycles;
                iter_q    <= (num_iter == '0) ? CNT_W'(1) : num_iter;
                reload_q  <= reload_w;
                wait_q    <= wait_ready;
            end
        end
    end

    npu_host_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (oe),
        .load_data_i (bus.npu_data_i),
        .can_load_o  (can_load),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (bus.out_data)
    );

endmodule

// File: tb/tb_npu_host_sequencer.sv
// tb_npu_host_sequencer: randomized self-checking bench for npu_host_sequencer.
module tb_npu_host_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] num_w, num_in_m1, num_out_m1, calc_cycles, num_iter;
    logic        reload_w, wait_ready;
    logic        busy, done;

    npu_host_sequencer_if #(.DATA_W(32)) bus ();

    npu_host_sequencer #(
        .DATA_W  (32),
        .NUM_CFG (6),
        .CNT_W   (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_w       (num_w),
        .num_in_m1   (num_in_m1),
        .num_out_m1  (num_out_m1),
        .calc_cycles (calc_cycles),
        .num_iter    (num_iter),
        .reload_w    (reload_w),
        .wait_ready  (wait_ready),
        .bus         (bus),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int src_pct, stall_after, ready_delay, busy_start_cyc, abort_after_we;

    logic [31:0] src_q[$], res_q[$], exp_out[$], obs_we[$], obs_out[$];
    int src_idx, res_idx, done_cnt, oe_cnt, we_run_max, oe_run_max, gap_first;
    int full_viol, overlap_viol, hold_viol, en_viol, timed_out;
    logic busy_at_done;

    function automatic int first_diff(input logic [31:0] a[$], input logic [31:0] b[$]);
        if (a.size() != b.size()) return -2;
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic set_knobs();
        src_pct        = 100;
        stall_after    = 0;
        ready_delay    = 0;
        busy_start_cyc = 4;
        abort_after_we = 0;
    endtask

    // Reference: the NPU must see every host word in stream order, and the result stream must
    // carry the NPU's answers in read order, one per requested output word.
    task automatic run_job(input int nw, input int nin_m1, input int nout_m1, input int calc,
                           input int iter, input bit reload, input bit waitr);
        int eff_iter = (iter == 0) ? 1 : iter;
        int n_out = eff_iter * (nout_m1 + 1);
        int cyc = 0, post = -1, last_we = -100, we_run = 0, oe_run = 0, stall_start = -1;
        bit prev_hold = 1'b0;
        logic [31:0] prev_data = '0;
        src_q.delete(); res_q.delete(); exp_out.delete(); obs_we.delete(); obs_out.delete();
        for (int it = 0; it < eff_iter; it++) begin
            if (it == 0 || reload) for (int k = 0; k < 6 + nw; k++) src_q.push_back($urandom);
            for (int k = 0; k <= nin_m1; k++) src_q.push_back($urandom);
        end
        for (int k = 0; k < n_out + 4; k++) res_q.push_back($urandom);
        for (int k = 0; k < n_out; k++) exp_out.push_back(res_q[k]);
        src_idx = 0; res_idx = 0; done_cnt = 0; oe_cnt = 0; we_run_max = 0; oe_run_max = 0;
        gap_first = -1; full_viol = 0; overlap_viol = 0; hold_viol = 0; en_viol = 0; busy_at_done = 1'b1;
        @(negedge clk);
        num_w = nw[11:0]; num_in_m1 = nin_m1[11:0]; num_out_m1 = nout_m1[11:0];
        calc_cycles = calc[11:0]; num_iter = iter[11:0]; reload_w = reload; wait_ready = waitr;
        start = 1'b1;
        while (cyc < 4000 && post != 0 && !(abort_after_we > 0 && obs_we.size() >= abort_after_we)) begin
            @(negedge clk);
            if (prev_hold && (!bus.out_valid || bus.out_data !== prev_data)) hold_viol++;
            if (bus.npu_we) begin
                obs_we.push_back(bus.npu_data_o);
                if (!bus.npu_data_en) en_viol++;
                last_we = cyc;
                we_run++;
                if (we_run > we_run_max) we_run_max = we_run;
            end else begin
                we_run = 0;
                if (bus.npu_data_en) en_viol++;
            end
            if (done) begin
                done_cnt++;
                if (post < 0) begin
                    post = 3;
                    busy_at_done = busy;
                end
            end
            start = (cyc == busy_start_cyc);
            if (cyc == 0) begin
                num_w = 12'($urandom); num_in_m1 = 12'($urandom); num_out_m1 = 12'($urandom);
                calc_cycles = 12'($urandom); num_iter = 12'($urandom);
                reload_w = ~reload; wait_ready = ~waitr;
            end
            bus.src_valid  = (src_idx < src_q.size()) && ($urandom_range(99) < src_pct);
            bus.src_data   = bus.src_valid ? src_q[src_idx] : $urandom;
            bus.out_ready  = !(stall_start >= 0 && cyc >= stall_start && cyc < stall_start + 4);
            bus.npu_data_i = (res_idx < res_q.size()) ? res_q[res_idx] : $urandom;
            bus.npu_ready  = (obs_we.size() == src_q.size()) && (cyc >= last_we + 1 + ready_delay);
            #1;
            if (bus.src_valid && bus.src_ready) src_idx++;
            if (bus.npu_oe) begin
                if (bus.npu_we || bus.npu_data_en) overlap_viol++;
                if (bus.out_valid && !bus.out_ready) full_viol++;
                if (oe_cnt == 0) gap_first = cyc - last_we;
                oe_cnt++;
                res_idx++;
                oe_run++;
                if (oe_run > oe_run_max) oe_run_max = oe_run;
                if (oe_cnt == stall_after) stall_start = cyc + 1;
            end else begin
                oe_run = 0;
            end
            if (bus.out_valid && bus.out_ready) obs_out.push_back(bus.out_data);
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            if (post > 0) post--;
            cyc++;
        end
        start = 1'b0;
        bus.src_valid = 1'b0;
        bus.out_ready = 1'b1;
        timed_out = (cyc >= 4000) ? 1 : 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.npu_we, bus.npu_oe, bus.npu_data_en, bus.out_valid, bus.src_ready, busy, done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {bus.npu_we, bus.npu_oe, bus.npu_data_en, bus.out_valid, bus.src_ready, busy, done});
        end
        checks++;
        if ({bus.npu_data_o, bus.out_data} !== 64'b0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {bus.npu_data_o, bus.out_data});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int d;
        set_knobs();
        run_job(11, 9, 0, 5, 1, 1'b1, 1'b0);
        checks++;
        if (timed_out != 0) begin errors++; $display("FAIL single_timeout: got %0d want 0", timed_out); end
        d = first_diff(obs_we, src_q);
        checks++;
        if (d != -1) begin errors++; $display("FAIL single_we_seq: diff at %0d, got %0d words want %0d", d, obs_we.size(), src_q.size()); end
        checks++;
        if (we_run_max != 27) begin errors++; $display("FAIL single_we_run: got %0d want 27", we_run_max); end
        checks++;
        if (gap_first != 6) begin errors++; $display("FAIL single_oe_gap: got %0d want 6", gap_first); end
        d = first_diff(obs_out, exp_out);
        checks++;
        if (d != -1) begin errors++; $display("FAIL single_out_seq: diff at %0d, got %0d words want %0d", d, obs_out.size(), exp_out.size()); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
        checks++;
        if (busy_at_done !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b want 0", busy_at_done); end
        checks++;
        if (overlap_viol + en_viol != 0) begin errors++; $display("FAIL single_bus_rules: got %0d want 0", overlap_viol + en_viol); end
    endtask

    task automatic test_iterations();
        int d;
        set_knobs();
        run_job(11, 9, 2, 3, 3, 1'b0, 1'b0);
        checks++;
        if (src_idx != 47) begin errors++; $display("FAIL iter_src_count: got %0d want 47", src_idx); end
        d = first_diff(obs_we, src_q);
        checks++;
        if (d != -1) begin errors++; $display("FAIL iter_we_seq: diff at %0d, got %0d words want %0d", d, obs_we.size(), src_q.size()); end
        d = first_diff(obs_out, exp_out);
        checks++;
        if (d != -1) begin errors++; $display("FAIL iter_out_seq: diff at %0d, got %0d words want %0d", d, obs_out.size(), exp_out.size()); end
        checks++;
        if (oe_run_max != 3) begin errors++; $display("FAIL iter_oe_run: got %0d want 3", oe_run_max); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL iter_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int d;
        set_knobs();
        src_pct = 60;
        stall_after = 2;
        run_job($urandom_range(1, 8), $urandom_range(0, 7), 3, $urandom_range(0, 4), 1, 1'b1, 1'b0);
        d = first_diff(obs_we, src_q);
        checks++;
        if (d != -1) begin errors++; $display("FAIL bp_we_seq: diff at %0d, got %0d words want %0d", d, obs_we.size(), src_q.size()); end
        d = first_diff(obs_out, exp_out);
        checks++;
        if (d != -1) begin errors++; $display("FAIL bp_out_seq: diff at %0d, got %0d words want %0d", d, obs_out.size(), exp_out.size()); end
        checks++;
        if (full_viol != 0) begin errors++; $display("FAIL bp_oe_while_full: got %0d want 0", full_viol); end
        checks++;
        if (hold_viol != 0) begin errors++; $display("FAIL bp_out_hold: got %0d want 0", hold_viol); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wait_ready();
        int d;
        set_knobs();
        ready_delay = 10;
        run_job(3, 2, 1, 2, 1, 1'b1, 1'b1);
        checks++;
        if (gap_first != 12) begin errors++; $display("FAIL wait_oe_gap: got %0d want 12", gap_first); end
        d = first_diff(obs_out, exp_out);
        checks++;
        if (d != -1) begin errors++; $display("FAIL wait_out_seq: diff at %0d, got %0d words want %0d", d, obs_out.size(), exp_out.size()); end
    endtask

    task automatic test_no_weights();
        int d;
        set_knobs();
        run_job(0, 4, 1, 1, 0, 1'b1, 1'b0);
        checks++;
        if (src_idx != 11) begin errors++; $display("FAIL nowgt_src_count: got %0d want 11", src_idx); end
        d = first_diff(obs_we, src_q);
        checks++;
        if (d != -1) begin errors++; $display("FAIL nowgt_we_seq: diff at %0d, got %0d words want %0d", d, obs_we.size(), src_q.size()); end
        d = first_diff(obs_out, exp_out);
        checks++;
        if (d != -1) begin errors++; $display("FAIL nowgt_out_seq: diff at %0d, got %0d words want %0d", d, obs_out.size(), exp_out.size()); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL nowgt_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_abort();
        int d, late_done = 0;
        set_knobs();
        busy_start_cyc = 3;
        abort_after_we = 8;
        run_job(10, 3, 1, 2, 1, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.npu_we, bus.npu_oe, bus.npu_data_en, bus.out_valid, bus.src_ready, busy, done} !== 7'b0) begin
            errors++;
            $display("FAIL abort_ctrl: got %b want 0000000",
                     {bus.npu_we, bus.npu_oe, bus.npu_data_en, bus.out_valid, bus.src_ready, busy, done});
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        checks++;
        if (late_done + done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", late_done + done_cnt); end
        set_knobs();
        busy_start_cyc = 6;
        run_job(5, 3, 1, 2, 1, 1'b1, 1'b0);
        d = first_diff(obs_we, src_q);
        checks++;
        if (d != -1) begin errors++; $display("FAIL abort_rerun_we: diff at %0d, got %0d words want %0d", d, obs_we.size(), src_q.size()); end
        d = first_diff(obs_out, exp_out);
        checks++;
        if (d != -1) begin errors++; $display("FAIL abort_rerun_out: diff at %0d, got %0d words want %0d", d, obs_out.size(), exp_out.size()); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL abort_rerun_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        int d;
        for (int j = 0; j < 4; j++) begin
            set_knobs();
            src_pct = $urandom_range(50, 100);
            stall_after = $urandom_range(0, 3);
            run_job($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 3),
                    $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom), 1'b0);
            d = first_diff(obs_we, src_q);
            checks++;
            if (d != -1) begin errors++; $display("FAIL rand%0d_we_seq: diff at %0d, got %0d words want %0d", j, d, obs_we.size(), src_q.size()); end
            d = first_diff(obs_out, exp_out);
            checks++;
            if (d != -1) begin errors++; $display("FAIL rand%0d_out_seq: diff at %0d, got %0d words want %0d", j, d, obs_out.size(), exp_out.size()); end
            checks++;
            if (done_cnt != 1 || full_viol + overlap_viol + hold_viol + en_viol != 0) begin
                errors++;
                $display("FAIL rand%0d_protocol: done %0d viol %0d, want done 1 viol 0", j, done_cnt,
                         full_viol + overlap_viol + hold_viol + en_viol);
            end
        end
    endtask

    initial begin
        start = 1'b0; num_w = '0; num_in_m1 = '0; num_out_m1 = '0; calc_cycles = '0; num_iter = '0;
        reload_w = 1'b0; wait_ready = 1'b0;
        bus.src_valid = 1'b0; bus.src_data = '0; bus.out_ready = 1'b1; bus.npu_data_i = '0; bus.npu_ready = 1'b0;
        test_reset();
        test_single();
        test_iterations();
        test_backpressure();
        test_wait_ready();
        test_no_weights();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
